// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and small decode helpers.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: restoring subtract for divide, conditional add then
// right shift of {acc, q} for multiply.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] opd_i,
   input  logic             is_div_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum    = {1'b0, acc_i} + {1'b0, opd_i};
      // acc < divisor always holds, so the shifted remainder fits in WIDTH+1 bits
      rem_sh = {acc_i, q_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, opd_i};
      acc_o  = acc_i;
      q_o    = q_i;
      if (is_div_i) begin
         if (!diff[WIDTH]) begin
            acc_o = diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {acc_i[WIDTH-2:0], q_i[WIDTH-1]};
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else if (q_i[0]) begin
         acc_o = sum[WIDTH:1];
         q_o   = {sum[0], q_i[WIDTH-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[WIDTH-1:1]};
         q_o   = {acc_i[0], q_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the execute stage: works on operand
// magnitudes for WIDTH cycles, then fixes signs and registers HI/LO.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               in_sign_a, in_sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   step_acc, step_q;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic               is_div;

   assign is_div = op_is_div(op_q);

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_i    (acc_q),
      .q_i      (q_q),
      .opd_i    (opd_q),
      .is_div_i (is_div),
      .acc_o    (step_acc),
      .q_o      (step_q)
   );

   // Operand magnitudes at acceptance and sign-corrected results for FIX.
   always_comb begin
      in_sign_a = op_is_signed(op) & srca[WIDTH-1];
      in_sign_b = op_is_signed(op) & srcb[WIDTH-1];
      mag_a     = in_sign_a ? -srca : srca;
      mag_b     = in_sign_b ? -srcb : srcb;
      prod      = {acc_q, q_q};
      if (sign_a_q ^ sign_b_q) begin
         prod = -prod;
      end
      quo = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
      rem = sign_a_q ? -acc_q : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      acc_d    = acc_q;
      q_d      = q_q;
      opd_d    = opd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !cancel) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               op_d     = op;
               sign_a_d = in_sign_a;
               sign_b_d = in_sign_b;
               acc_d    = '0;
               // Divide shifts the dividend through q; multiply shifts the multiplier.
               q_d      = op_is_div(op) ? mag_a : mag_b;
               opd_d    = op_is_div(op) ? mag_b : mag_a;
            end
         end
         ST_RUN: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               q_d   = step_q;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
               if (is_div) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         acc_q    <= '0;
         q_q      <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         opd_q    <= opd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign hi_o  = hi_q;
   assign lo_o  = lo_q;
   assign stall = start & ~done_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed vector table, flush/reset/back-to-back
// sequences and random operations against a 64-bit arithmetic model.
module tb_muldiv_iter;

   localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

   logic        clk = 1'b0;
   logic        rst, start, cancel;
   logic [1:0]  op;
   logic [31:0] srca, srcb;
   logic        busy, done, stall;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_iter #(
      .WIDTH (32)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .cancel (cancel),
      .srca   (srca),
      .srcb   (srcb),
      .busy   (busy),
      .done   (done),
      .stall  (stall),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, qq, rr;
      logic [63:0] r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (o)
         MULT:  r = 64'(sa * sb);
         MULTU: r = ua * ub;
         DIV: begin
            if (b == 32'd0) begin
               r = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
            end else begin
               qq = sa / sb;
               rr = sa % sb;
               r  = {rr[31:0], qq[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return r;
   endfunction

   // Called #1 after a posedge in an idle cycle (cycle 0); returns #1 after the
   // edge following the done cycle. lat counts edges until done (-1 on timeout).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output int lat,
                         output bit stall_ok);
      h = 'x;
      l = 'x;
      lat = -1;
      stall_ok = 1'b1;
      op = o;
      srca = a;
      srcb = b;
      start = 1'b1;
      #1;
      if (stall !== 1'b1) stall_ok = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
         if (stall !== 1'b1) stall_ok = 1'b0;
      end
      if (lat > 0) begin
         h = hi_o;
         l = lo_o;
         if (stall !== 1'b0) stall_ok = 1'b0;
      end
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   vec_t        vecs[9];
   logic [31:0] h, l, ph, pl, h1, l1;
   int          lat;
   bit          sok, saw_done;
   logic [63:0] exp;

   function automatic logic [31:0] pick();
      logic [31:0] sp[5];
      sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'h8000_0000;
      sp[3] = 32'h7FFF_FFFF; sp[4] = 32'h1;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300));
      return $urandom;
   endfunction

   initial begin
      vecs[0] = '{"multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{"mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{"div_neg7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{"divu_by0", DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF};
      vecs[4] = '{"div_minneg", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
      vecs[5] = '{"div_neg_by0", DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'h1};
      vecs[6] = '{"div_pos_by0", DIV, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF};
      vecs[7] = '{"mult_minsq", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
      vecs[8] = '{"div_7dneg2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD};

      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = MULT; srca = '0; srcb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi_o), 64'd0);
      chk("reset_lo", 64'(lo_o), 64'd0);
      chk("reset_stall_lo", 64'(stall), 64'd0);
      start = 1'b1;
      #1;
      chk("reset_stall_hi", 64'(stall), 64'd1);
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, lat, sok);
         chk({vecs[i].name, "_hi"}, 64'(h), 64'(vecs[i].hi));
         chk({vecs[i].name, "_lo"}, 64'(l), 64'(vecs[i].lo));
         chk({vecs[i].name, "_lat"}, 64'(lat), 64'd34);
         chk({vecs[i].name, "_stall"}, 64'(sok), 64'd1);
      end

      // Flush during RUN at cycle 10, then a new op in cycle 11.
      ph = hi_o; pl = lo_o; saw_done = 1'b0;
      op = DIVU; srca = 32'd5000; srcb = 32'd3; start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("cancel_run_busy_before", 64'(busy), 64'd1);
      cancel = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      chk("cancel_run_busy", 64'(busy), 64'd0);
      chk("cancel_run_done", 64'({saw_done, done}), 64'd0);
      chk("cancel_run_hi", 64'(hi_o), 64'(ph));
      chk("cancel_run_lo", 64'(lo_o), 64'(pl));
      run_op(DIVU, 32'd1000, 32'd7, h, l, lat, sok);
      chk("after_cancel_lat", 64'(lat), 64'd34);
      chk("after_cancel_res", {h, l}, {32'd6, 32'd142});

      // Flush during FIX (cycle 33).
      ph = hi_o; pl = lo_o; saw_done = 1'b0;
      op = MULTU; srca = 32'd3; srcb = 32'd5; start = 1'b1;
      for (int i = 0; i < 33; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      cancel = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      chk("cancel_fix_done", 64'({saw_done, done}), 64'd0);
      chk("cancel_fix_busy", 64'(busy), 64'd0);
      chk("cancel_fix_hilo", {hi_o, lo_o}, {ph, pl});

      // Start and cancel together in IDLE must not be accepted.
      op = MULTU; srca = 32'd9; srcb = 32'd9; start = 1'b1; cancel = 1'b1;
      @(posedge clk);
      #1;
      chk("start_cancel_busy", 64'(busy), 64'd0);
      start = 1'b0; cancel = 1'b0;
      @(posedge clk);
      #1;
      chk("start_cancel_idle", 64'(busy), 64'd0);

      // Reset in cycle 5 of a MULT.
      op = MULT; srca = 32'hFFFF_FFFD; srcb = 32'd7; start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midreset_outs", {28'd0, busy, done, stall, 1'b0, hi_o, lo_o}, 64'd0);
      @(posedge clk);
      #1;
      chk("midreset_after", 64'({busy, done}), 64'd0);

      // Back-to-back DIVU with start held high.
      begin
         int t, t1, t2;
         t = 0; t1 = -1; t2 = -1;
         op = DIVU; srca = 32'd1000; srcb = 32'd7; start = 1'b1;
         for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(posedge clk);
            #1;
            t++;
            if (done === 1'b1) begin
               if (t1 < 0) begin
                  t1 = t; h1 = hi_o; l1 = lo_o;
                  srca = 32'hFFFF_FFFF; srcb = 32'h10;
               end else begin
                  t2 = t; h = hi_o; l = lo_o;
               end
            end
         end
         start = 1'b0;
         @(posedge clk);
         #1;
         chk("b2b_first_lat", 64'(t1), 64'd34);
         chk("b2b_spacing", 64'(t2 - t1), 64'd35);
         chk("b2b_first_res", {h1, l1}, {32'd6, 32'd142});
         chk("b2b_second_res", {h, l}, {32'hF, 32'h0FFF_FFFF});
      end

      for (int n = 0; n < 150; n++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         exp = ref_model(ro, ra, rb);
         run_op(ro, ra, rb, h, l, lat, sok);
         if ({h, l} !== exp)
            $display("  op=%0d a=%h b=%h", ro, ra, rb);
         chk("random", {h, l}, exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
